// File: rtl/qbus_dma_if.sv
// Bus-side signals shared by the CPU sequencer, the external DMA master and the arbiter.
// slave = arbiter view, master = the agents driving requests/replies.
interface qbus_dma_if;
    logic       cpu_sync;
    logic       rply;
    logic       dmr;
    logic       sack;
    logic       dmgo;
    logic       cpu_hold;
    logic       bus_error;
    logic       dma_owner;
    logic [7:0] to_count;

    modport slave (
        input  cpu_sync, rply, dmr, sack,
        output dmgo, cpu_hold, bus_error, dma_owner, to_count
    );

    modport master (
        output cpu_sync, rply, dmr, sack,
        input  dmgo, cpu_hold, bus_error, dma_owner, to_count
    );
endinterface

// File: rtl/qbus_dma_arbiter.sv
// 1801VM1 bus ownership arbiter: DMR/DMGO/SACK grant handshake, CPU hold-off and
// RPLY watchdog sharing one timeout counter with the grant-offer timeout.
module qbus_dma_arbiter #(
    parameter int BUS_TIMEOUT = 63,
    parameter int TO_W        = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    qbus_dma_if.slave  bus
);
    typedef enum logic [1:0] {S_CPU, S_OFFER, S_DMA, S_REL} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUS_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] timer, timer_nxt;
    logic            err_q, err_nxt;
    logic [7:0]      cnt_q, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_CPU;
            timer <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else if (ce) begin
            state <= state_nxt;
            timer <= timer_nxt;
            err_q <= err_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        err_nxt   = err_q;
        cnt_nxt   = cnt_q;
        if (!bus.cpu_sync)
            err_nxt = 1'b0;
        unique case (state)
            S_CPU: begin
                if (!bus.cpu_sync || bus.rply) begin
                    timer_nxt = '0;
                end else if (!err_q) begin
                    // Once timed out, the timer parks until the cycle ends or RPLY arrives.
                    if (timer == TO_LIMIT) begin
                        err_nxt = 1'b1;
                        if (cnt_q != 8'hFF)
                            cnt_nxt = cnt_q + 8'd1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                if (bus.dmr && !bus.cpu_sync) begin
                    state_nxt = S_OFFER;
                    timer_nxt = '0;
                end
            end
            S_OFFER: begin
                if (bus.sack) begin
                    state_nxt = S_DMA;
                    timer_nxt = '0;
                end else if (!bus.dmr || timer == TO_LIMIT) begin
                    state_nxt = S_CPU;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_DMA: begin
                if (!bus.sack)
                    state_nxt = S_REL;
            end
            // Turnaround always returns to S_CPU so the CPU gets a hold-free cycle.
            S_REL: state_nxt = S_CPU;
            default: state_nxt = S_CPU;
        endcase
    end

    // Outputs decode straight from state so reset drops them asynchronously.
    assign bus.dmgo      = (state == S_OFFER);
    assign bus.cpu_hold  = (state != S_CPU);
    assign bus.dma_owner = (state == S_DMA);
    assign bus.bus_error = err_q;
    assign bus.to_count  = cnt_q;
endmodule
